// File: rtl/pic_priority_isr_pkg.sv
// Shared types and constants for the PIC priority resolver / in-service stage.
package pic_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WAIT2 = 1'b1
  } pic_state_e;

  // OCW2 {R, SL, EOI} encodings that do something; the rest are no-ops.
  localparam logic [2:0] OCW2_NS_EOI  = 3'b001;
  localparam logic [2:0] OCW2_SP_EOI  = 3'b011;
  localparam logic [2:0] OCW2_ROT_NS  = 3'b101;
  localparam logic [2:0] OCW2_ROT_SP  = 3'b111;
  localparam logic [2:0] OCW2_SET_PRI = 3'b110;

  // Level reported in the vector when an acknowledge finds nothing pending.
  localparam logic [2:0] SPURIOUS_LVL = 3'd7;

  // Priority rank of a level given the lowest-priority level L (0 = highest).
  function automatic logic [2:0] prio_rank(input logic [2:0] lvl, input logic [2:0] low);
    return lvl - low - 3'd1;
  endfunction

  // One-hot decode of a level.
  function automatic logic [7:0] onehot8(input logic [2:0] lvl);
    return 8'b1 << lvl;
  endfunction

endpackage

// File: rtl/pic_priority_isr_if.sv
// Bundle of request, control and result signals around the priority/ISR stage.
// Handshake: inta_pulse and ocw2_valid are single-cycle strobes with no ready;
// the stage always accepts them. irr_clear and vector_valid are single-cycle
// strobes back to the producer with no backpressure.
interface pic_priority_isr_if;
  import pic_pkg::*;

  logic       irr_dummy_unused;
  logic [7:0] irr;
  logic       aeoi;
  logic       auto_rotate;
  logic [4:0] vector_base;
  logic       inta_pulse;
  logic       ocw2_valid;
  logic [2:0] ocw2_cmd;
  logic [2:0] ocw2_level;

  logic       int_out;
  logic [7:0] irr_clear;
  logic [7:0] isr;
  logic [2:0] lowest_level;
  logic [7:0] vector;
  logic       vector_valid;
  pic_state_e dbg_state;

  // Master drives requests and commands; slave is the PIC stage.
  modport master (
    output irr, aeoi, auto_rotate, vector_base, inta_pulse,
           ocw2_valid, ocw2_cmd, ocw2_level,
    input  int_out, irr_clear, isr, lowest_level, vector, vector_valid, dbg_state
  );

  modport slave (
    input  irr, aeoi, auto_rotate, vector_base, inta_pulse,
           ocw2_valid, ocw2_cmd, ocw2_level,
    output int_out, irr_clear, isr, lowest_level, vector, vector_valid, dbg_state
  );

endinterface

// File: rtl/pic_priority_isr_encoder.sv
// Rotating priority encoder: the highest-priority set bit of vec when the
// lowest-priority level is L (search order L+1, L+2, ... wrapping to L).
module pic_prio_encoder (
  input  logic [7:0] vec,
  input  logic [2:0] L,
  output logic       found,
  output logic [2:0] level
);

  // Walk the levels in priority order and keep the first one that is set.
  always_comb begin
    logic [2:0] idx;
    found = 1'b0;
    level = 3'd0;
    idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = L + 3'd1 + i[2:0];
      if (vec[idx] && !found) begin
        found = 1'b1;
        level = idx;
      end
    end
  end

endmodule

// File: rtl/pic_priority_isr.sv
// Priority resolver and In-Service Register stage of an 8259-style PIC:
// resolves the pending request, runs the two-pulse INTA sequence and
// applies OCW2 end-of-interrupt / rotation commands.
module pic_priority_isr
  import pic_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  pic_priority_isr_if.slave  bus
);

  pic_state_e state_q;
  logic [2:0] lvl_q;
  logic       spurious_q;
  logic [7:0] isr_q, isr_d;
  logic [2:0] low_q, low_d;
  logic       int_out_q;
  logic [7:0] irr_clear_q;
  logic [7:0] vector_q;
  logic       vector_valid_q;

  logic       irr_found, isr_found, cand_found;
  logic [2:0] irr_lvl, isr_lvl;
  logic [7:0] ocw2_clear, aeoi_clear, inta_set;
  logic       ocw2_set_l, aeoi_rot;
  logic [2:0] ocw2_l;
  logic       ack1, ack2;

  pic_prio_encoder u_irr_enc (
    .vec   (bus.irr),
    .L     (low_q),
    .found (irr_found),
    .level (irr_lvl)
  );

  pic_prio_encoder u_isr_enc (
    .vec   (isr_q),
    .L     (low_q),
    .found (isr_found),
    .level (isr_lvl)
  );

  // A request is a candidate only if it outranks everything in service.
  // The best pending request is enough: if it does not outrank isr_top, none does.
  assign cand_found = irr_found &&
                      (!isr_found || (prio_rank(irr_lvl, low_q) < prio_rank(isr_lvl, low_q)));

  assign ack1 = (state_q == IDLE)  && bus.inta_pulse;
  assign ack2 = (state_q == WAIT2) && bus.inta_pulse;

  // OCW2 decode against the pre-update isr and L; EOI forms need something in service.
  always_comb begin
    ocw2_clear = 8'h00;
    ocw2_set_l = 1'b0;
    ocw2_l     = low_q;
    if (bus.ocw2_valid) begin
      case (bus.ocw2_cmd)
        OCW2_NS_EOI: begin
          if (isr_found) ocw2_clear = onehot8(isr_lvl);
        end
        OCW2_SP_EOI: begin
          if (isr_found) ocw2_clear = onehot8(bus.ocw2_level);
        end
        OCW2_ROT_NS: begin
          if (isr_found) begin
            ocw2_clear = onehot8(isr_lvl);
            ocw2_set_l = 1'b1;
            ocw2_l     = isr_lvl;
          end
        end
        OCW2_ROT_SP: begin
          if (isr_found) begin
            ocw2_clear = onehot8(bus.ocw2_level);
            ocw2_set_l = 1'b1;
            ocw2_l     = bus.ocw2_level;
          end
        end
        OCW2_SET_PRI: begin
          ocw2_set_l = 1'b1;
          ocw2_l     = bus.ocw2_level;
        end
        default: ;
      endcase
    end
  end

  // ISR and L next state: acknowledge set beats any clear; OCW2 beats AEOI rotation.
  always_comb begin
    inta_set   = (ack1 && cand_found) ? onehot8(irr_lvl) : 8'h00;
    aeoi_clear = (ack2 && bus.aeoi && !spurious_q) ? onehot8(lvl_q) : 8'h00;
    aeoi_rot   = ack2 && bus.aeoi && bus.auto_rotate && !spurious_q;
    isr_d      = (isr_q & ~ocw2_clear & ~aeoi_clear) | inta_set;
    if (ocw2_set_l)    low_d = ocw2_l;
    else if (aeoi_rot) low_d = lvl_q;
    else               low_d = low_q;
  end

  // Acknowledge FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      lvl_q          <= 3'd0;
      spurious_q     <= 1'b0;
      isr_q          <= 8'h00;
      low_q          <= 3'd7;
      int_out_q      <= 1'b0;
      irr_clear_q    <= 8'h00;
      vector_q       <= 8'h00;
      vector_valid_q <= 1'b0;
    end else begin
      isr_q <= isr_d;
      low_q <= low_d;
      case (state_q)
        IDLE: begin
          vector_valid_q <= 1'b0;
          if (bus.inta_pulse) begin
            state_q     <= WAIT2;
            int_out_q   <= 1'b0;
            spurious_q  <= !cand_found;
            lvl_q       <= cand_found ? irr_lvl : SPURIOUS_LVL;
            irr_clear_q <= cand_found ? onehot8(irr_lvl) : 8'h00;
          end else begin
            int_out_q   <= cand_found;
            irr_clear_q <= 8'h00;
          end
        end
        WAIT2: begin
          int_out_q   <= 1'b0;
          irr_clear_q <= 8'h00;
          if (bus.inta_pulse) begin
            state_q        <= IDLE;
            vector_q       <= {bus.vector_base, lvl_q};
            vector_valid_q <= 1'b1;
          end else begin
            vector_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.int_out      = int_out_q;
  assign bus.irr_clear    = irr_clear_q;
  assign bus.isr          = isr_q;
  assign bus.lowest_level = low_q;
  assign bus.vector       = vector_q;
  assign bus.vector_valid = vector_valid_q;
  assign bus.dbg_state    = state_q;

endmodule
